// File: rtl/sd_controller_buffer_pkg.sv
// Shared helpers for the SD controller N-slot buffer ring.
package sd_controller_buffer_pkg;

    localparam int unsigned DEF_BUF_COUNT  = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    function automatic int unsigned BUF_IDX_WIDTH(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned strb_width(input int unsigned dw);
        return dw / 8;
    endfunction

    localparam int unsigned STRB_WIDTH = strb_width(DEF_DATA_WIDTH);

    typedef logic [BUF_IDX_WIDTH(DEF_BUF_COUNT):0] buf_level_t;

endpackage

// File: rtl/sd_controller_buffer_mem.sv
// Byte-strobed simple dual-port RAM holding all ring slots, registered read port.
module sd_controller_buffer_mem
    import sd_controller_buffer_pkg::*;
#(
    parameter int unsigned MEM_AW     = 9,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              we,
    input  logic [MEM_AW-1:0]                 waddr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0] wstrb,
    input  logic [MEM_AW-1:0]                 raddr,
    output logic [DATA_WIDTH-1:0]             rdata
);

    localparam int unsigned STRB_W = strb_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (we && wstrb[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sd_controller_multi_buffer_ring.sv
// N-slot FIFO-ordered buffer ring between the SD data-line engine and AXI DMA.
// Optional sticky overflow/underflow flags: define SD_CONTROLLER_BUFFER_ERR_EN.
module sd_controller_multi_buffer_ring
    import sd_controller_buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PROP_WIDTH = 32,
    parameter int unsigned BUF_COUNT  = 4
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              flush,
    input  logic [ADDR_WIDTH-1:0]             waddr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0] wstrb,
    input  logic                              we,
    input  logic [PROP_WIDTH-1:0]             wprop,
    input  logic                              wcommit,
    output logic                              wvalid,
    input  logic [ADDR_WIDTH-1:0]             raddr,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic [PROP_WIDTH-1:0]             rprop,
    input  logic                              rrelease,
    output logic                              rvalid,
    output logic [$clog2(BUF_COUNT):0]        level
`ifdef SD_CONTROLLER_BUFFER_ERR_EN
    ,
    output logic                              err_overflow,
    output logic                              err_underflow,
    input  logic                              err_clear
`endif
);

    localparam int unsigned IDX_W = BUF_IDX_WIDTH(BUF_COUNT);
    localparam int unsigned LVL_W = IDX_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(BUF_COUNT);
    localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             do_commit, do_release;

    logic [PROP_WIDTH-1:0] prop_mem [BUF_COUNT];

    always_comb begin
        wvalid     = (count_q != FULL_LVL);
        rvalid     = (count_q != '0);
        level      = count_q;
        do_commit  = wcommit && wvalid;
        do_release = rrelease && rvalid;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        count_d    = count_q;
        if (do_commit) begin
            wr_idx_d = wr_idx_q + ONE_IDX;
        end
        if (do_release) begin
            rd_idx_d = rd_idx_q + ONE_IDX;
        end
        if (do_commit && !do_release) begin
            count_d = count_q + ONE_LVL;
        end else if (!do_commit && do_release) begin
            count_d = count_q - ONE_LVL;
        end
        if (flush) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    // A property written alongside a flush is harmless: the slot is logically gone.
    always_ff @(posedge aclk) begin
        if (do_commit) begin
            prop_mem[wr_idx_q] <= wprop;
        end
    end

    assign rprop = prop_mem[rd_idx_q];

    sd_controller_buffer_mem #(
        .MEM_AW     (IDX_W + ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (aclk),
        .rst_n (aresetn),
        .we    (we && wvalid),
        .waddr ({wr_idx_q, waddr}),
        .wdata (wdata),
        .wstrb (wstrb),
        .raddr ({rd_idx_q, raddr}),
        .rdata (rdata)
    );

`ifdef SD_CONTROLLER_BUFFER_ERR_EN
    logic err_ovf_q, err_ovf_d;
    logic err_unf_q, err_unf_d;

    // Setting is evaluated last so a coincident clear cannot hide a new error.
    always_comb begin
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        if (err_clear || flush) begin
            err_ovf_d = 1'b0;
            err_unf_d = 1'b0;
        end
        if ((wcommit || we) && !wvalid) begin
            err_ovf_d = 1'b1;
        end
        if (rrelease && !rvalid) begin
            err_unf_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;
`endif

endmodule

// File: doc/sd_controller_multi_buffer_ring.md
Name: sd_controller_multi_buffer_ring

Overview:
- Parametrised N-slot buffer ring between the SD data-line engine and the AXI DMA side.
- Generalises the two-slot ping-pong scheme:
  - BUF_COUNT slots with FIFO ordering.
  - Independent producer commit and consumer release; either side may run up to BUF_COUNT-1 blocks ahead.
  - Byte-strobed writes, registered read port, per-slot property word, synchronous flush.

Parameters:
- ADDR_WIDTH, 7, word address width within one slot (depth 2**ADDR_WIDTH words).
- DATA_WIDTH, 32, data word width; must be a multiple of 8.
- PROP_WIDTH, 32, per-slot property/tag width (block address, CRC status, etc.).
- BUF_COUNT, 4, number of slots; power of two, at least 2.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all slots.
- waddr  in  ADDR_WIDTH  write word address in the current write slot.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte enables.
- we  in  1  write enable.
- wprop  in  PROP_WIDTH  property stored on commit.
- wcommit  in  1  publish the current write slot.
- wvalid  out  1  a free write slot is owned by the producer.
- raddr  in  ADDR_WIDTH  read word address in the head slot.
- rdata  out  DATA_WIDTH  registered read data.
- rprop  out  PROP_WIDTH  property of the head slot.
- rrelease  in  1  free the head slot.
- rvalid  out  1  head slot holds committed data.
- level  out  $clog2(BUF_COUNT)+1  number of committed slots.

Behaviour:
- State: wr_idx and rd_idx, each $clog2(BUF_COUNT) bits, wrapping modulo BUF_COUNT; count, 0..BUF_COUNT.
- Reset (asynchronous, aresetn=0):
  - wr_idx=0, rd_idx=0, count=0.
  - wvalid=1, rvalid=0, level=0, rdata=0.
  - Memory and property contents are not reset.
- Derived outputs: wvalid = (count != BUF_COUNT); rvalid = (count != 0); level = count. All come from registered state, with no combinational path from inputs.
- Accepted events:
  - Commit is accepted when wcommit && wvalid. It stores wprop into prop[wr_idx], increments wr_idx and increments count.
  - Release is accepted when rrelease && rvalid. It increments rd_idx and decrements count.
  - Commit and release accepted in the same cycle: both pointers advance and count is unchanged.
  - wcommit while full and rrelease while empty are ignored: no state change.
- Writes: when we && wvalid, for each byte b with wstrb[b]=1, mem[wr_idx][waddr] byte b <= wdata byte b.
  - Writes while !wvalid are dropped.
  - A write and a commit in the same cycle: the write lands in the slot being committed.
- Reads:
  - rdata is registered with 1-cycle latency: rdata(t+1) = mem[rd_idx(t)][raddr(t)].
  - A release at t does not affect rdata(t+1); the new head is visible from raddr sampled at t+1.
  - rdata updates every cycle regardless of rvalid. The value is meaningless while rvalid=0.
- rprop = prop[rd_idx] is combinational from registered state and is valid whenever rvalid=1.
- Flush: when flush=1, next state is wr_idx=rd_idx=0 and count=0. Flush has priority over commit/release in the same cycle. A write in the same cycle is still performed into the old wr_idx slot but is discarded logically.
- Mid-operation reset behaves like flush but is immediate. Any partially written slot is abandoned.

Optional Feature:
- Macro: SD_CONTROLLER_BUFFER_ERR_EN.
- When defined, adds three ports:
  - err_overflow, output, 1 bit.
  - err_underflow, output, 1 bit.
  - err_clear, input, 1 bit.
- Flag behaviour:
  - err_overflow is set sticky on a wcommit or we while !wvalid.
  - err_underflow is set sticky on rrelease while !rvalid.
  - Both flags clear on err_clear, on flush, or on reset. A set and err_clear in the same cycle leaves the flag set.
- When undefined, the ports are absent, illegal requests are silently ignored, and there is no extra logic.

Decomposition:
- Package sd_controller_buffer_pkg:
  - BUF_IDX_WIDTH function ($clog2 wrapper).
  - typedef buf_level_t.
  - Localparam STRB_WIDTH = DATA_WIDTH/8 helper.
- One sub-module, sd_controller_buffer_mem: a BUF_COUNT*2**ADDR_WIDTH byte-strobed simple dual-port RAM with registered read, addressed by {idx, addr}, so synthesis infers block RAM.
- Pointer/count control stays in the top module.

Test Plan:
- Reset then fill:
  - After reset, wvalid=1, rvalid=0, level=0.
  - Commit 4 slots with wprop 0xA0..0xA3: level reaches 4, wvalid=0, and a 5th commit is ignored (level stays 4).
- Data integrity:
  - Write slot 0 with waddr=5, wdata=0x11223344, wstrb=4'b0101, over a prior 0xFFFFFFFF, then commit.
  - With raddr=5, rdata one cycle later = 0xFF22FF44 and rprop = 0xA0.
- Simultaneous commit and release at level=2: level stays 2, both pointers advance, and rprop shows the next slot's property.
- Wrap-around: 10 commit/release pairs with BUF_COUNT=4; each slot's data and prop match, in order, across the index wrap 3->0.
- Flush and reset:
  - Flush at level=3 together with wcommit: next cycle level=0, rvalid=0, wvalid=1.
  - aresetn pulled low mid-write clears outputs asynchronously, before the next clock edge.
- SD_CONTROLLER_BUFFER_ERR_EN:
  - rrelease while empty sets err_underflow=1 and it holds.
  - err_clear returns it to 0.
  - A commit while full sets err_overflow.
